// File: rtl/i2c_slave_regfile.sv
// I2C responder backed by a 2**ADDR_W byte register file, with glitch-filtered pad
// inputs, a local read port and a strobe that reports every byte written over I2C.
module i2c_slave_regfile #(
  parameter logic [6:0] SLAVE_ADDR = 7'h50,
  parameter int         ADDR_W     = 4,
  parameter int         FILT       = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              scl_pad_i,
  output logic              scl_pad_o,
  output logic              scl_padoen_o,
  input  logic              sda_pad_i,
  output logic              sda_pad_o,
  output logic              sda_padoen_o,
  input  logic [ADDR_W-1:0] loc_addr,
  output logic [7:0]        loc_data,
  output logic              wr_stb,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic              busy
);
  localparam int DEPTH = 2**ADDR_W;
  localparam int CNT_W = $clog2(FILT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FILT - 1);

  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK
  } state_t;

  logic             scl_p0, scl_p1, scl_f, scl_fd;
  logic             sda_p0, sda_p1, sda_f, sda_fd;
  logic [CNT_W-1:0] scl_cnt, sda_cnt;
  logic             scl_rise, scl_fall, start_c, stop_c;

  state_t            state;
  logic [3:0]        bitcnt;
  logic [7:0]        shreg;
  logic [7:0]        byte_in;
  logic [ADDR_W-1:0] ptr;
  logic              rw;
  logic              rd_ack;
  logic [7:0]        mem [DEPTH];

  assign scl_pad_o    = 1'b0;
  assign scl_padoen_o = 1'b1;
  assign sda_pad_o    = 1'b0;

  // Stage p0/p1: two-flop synchronizer, then a level must persist FILT cycles to be accepted
  always_ff @(posedge clk) begin
    if (rst) begin
      scl_p0  <= scl_pad_i;
      scl_p1  <= scl_pad_i;
      scl_f   <= scl_pad_i;
      scl_fd  <= scl_pad_i;
      scl_cnt <= '0;
      sda_p0  <= sda_pad_i;
      sda_p1  <= sda_pad_i;
      sda_f   <= sda_pad_i;
      sda_fd  <= sda_pad_i;
      sda_cnt <= '0;
    end else begin
      scl_p0 <= scl_pad_i;
      scl_p1 <= scl_p0;
      sda_p0 <= sda_pad_i;
      sda_p1 <= sda_p0;
      scl_fd <= scl_f;
      sda_fd <= sda_f;
      if (scl_p1 == scl_f) begin
        scl_cnt <= '0;
      end else if (scl_cnt == CNT_MAX) begin
        scl_f   <= scl_p1;
        scl_cnt <= '0;
      end else begin
        scl_cnt <= scl_cnt + 1'b1;
      end
      if (sda_p1 == sda_f) begin
        sda_cnt <= '0;
      end else if (sda_cnt == CNT_MAX) begin
        sda_f   <= sda_p1;
        sda_cnt <= '0;
      end else begin
        sda_cnt <= sda_cnt + 1'b1;
      end
    end
  end

  assign scl_rise = scl_f & ~scl_fd;
  assign scl_fall = ~scl_f & scl_fd;
  assign start_c  = scl_f & scl_fd & sda_fd & ~sda_f;
  assign stop_c   = scl_f & scl_fd & ~sda_fd & sda_f;
  assign byte_in  = {shreg[6:0], sda_f};

  // Protocol FSM: sample on scl_rise, change SDA drive only on scl_fall
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      bitcnt       <= '0;
      shreg        <= '0;
      ptr          <= '0;
      rw           <= 1'b0;
      rd_ack       <= 1'b0;
      sda_padoen_o <= 1'b1;
      busy         <= 1'b0;
      wr_stb       <= 1'b0;
      wr_addr      <= '0;
      wr_data      <= '0;
      mem          <= '{default: '0};
    end else begin
      wr_stb <= 1'b0;
      if (start_c) begin
        state        <= ADDR;
        bitcnt       <= '0;
        rd_ack       <= 1'b0;
        sda_padoen_o <= 1'b1;
      end else if (stop_c) begin
        state        <= IDLE;
        bitcnt       <= '0;
        rd_ack       <= 1'b0;
        sda_padoen_o <= 1'b1;
        busy         <= 1'b0;
      end else begin
        case (state)
          ADDR, PTR, WDATA: begin
            if (scl_rise && bitcnt < 4'd8) begin
              shreg  <= byte_in;
              bitcnt <= bitcnt + 4'd1;
              if (state == WDATA && bitcnt == 4'd7) begin
                mem[ptr] <= byte_in;
                wr_stb   <= 1'b1;
                wr_addr  <= ptr;
                wr_data  <= byte_in;
              end
            end else if (scl_fall && bitcnt == 4'd8) begin
              bitcnt <= '0;
              case (state)
                ADDR: begin
                  if (shreg[7:1] == SLAVE_ADDR) begin
                    rw           <= shreg[0];
                    busy         <= 1'b1;
                    sda_padoen_o <= 1'b0;
                    state        <= ADDR_ACK;
                  end else begin
                    sda_padoen_o <= 1'b1;
                    busy         <= 1'b0;
                    state        <= IDLE;
                  end
                end
                PTR: begin
                  ptr          <= shreg[ADDR_W-1:0];
                  sda_padoen_o <= 1'b0;
                  state        <= PTR_ACK;
                end
                default: begin
                  sda_padoen_o <= 1'b0;
                  state        <= WDATA_ACK;
                end
              endcase
            end
          end
          ADDR_ACK: begin
            if (scl_fall) begin
              if (rw) begin
                sda_padoen_o <= mem[ptr][7];
                shreg        <= {mem[ptr][6:0], 1'b1};
                state        <= RDATA;
              end else begin
                sda_padoen_o <= 1'b1;
                state        <= PTR;
              end
            end
          end
          PTR_ACK: begin
            if (scl_fall) begin
              sda_padoen_o <= 1'b1;
              state        <= WDATA;
            end
          end
          WDATA_ACK: begin
            if (scl_fall) begin
              sda_padoen_o <= 1'b1;
              ptr          <= ptr + ADDR_W'(1);
              state        <= WDATA;
            end
          end
          RDATA: begin
            if (scl_rise && bitcnt < 4'd8) begin
              bitcnt <= bitcnt + 4'd1;
            end else if (scl_fall) begin
              if (bitcnt == 4'd8) begin
                bitcnt       <= '0;
                rd_ack       <= 1'b0;
                sda_padoen_o <= 1'b1;
                state        <= RDATA_ACK;
              end else begin
                sda_padoen_o <= shreg[7];
                shreg        <= {shreg[6:0], 1'b1};
              end
            end
          end
          RDATA_ACK: begin
            if (scl_rise) begin
              if (!sda_f) begin
                ptr    <= ptr + ADDR_W'(1);
                rd_ack <= 1'b1;
              end else begin
                busy  <= 1'b0;
                state <= IDLE;
              end
            end else if (scl_fall && rd_ack) begin
              rd_ack       <= 1'b0;
              sda_padoen_o <= mem[ptr][7];
              shreg        <= {mem[ptr][6:0], 1'b1};
              state        <= RDATA;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Local read port: registered, sees the pre-write byte on a same-cycle collision
  always_ff @(posedge clk) begin
    if (rst) loc_data <= '0;
    else     loc_data <= mem[loc_addr];
  end

endmodule

// File: tb/tb_i2c_slave_regfile.sv
// Bench for i2c_slave_regfile: bit-banged I2C master, register-file reference model,
// write-strobe monitor and directed plus randomized transactions.
module tb_i2c_slave_regfile;
  localparam int Q = 10;
  localparam int H = 20;
  localparam logic [6:0] SA = 7'h50;

  logic       clk = 1'b0;
  logic       rst, scl_m, sda_m, sda_line;
  logic       scl_pad_o, scl_padoen_o, sda_pad_o, sda_padoen_o;
  logic [3:0] loc_addr, wr_addr;
  logic [7:0] loc_data, wr_data;
  logic       wr_stb, busy;

  int checks = 0;
  int errors = 0;
  int drive_cnt = 0;
  logic [11:0] stbq[$];
  logic [7:0]  wbuf[$];
  logic [7:0]  mdl_mem[16];
  int          mdl_ptr;

  always #5 clk = ~clk;
  assign sda_line = sda_m & sda_padoen_o;

  i2c_slave_regfile #(.SLAVE_ADDR(SA), .ADDR_W(4), .FILT(3)) dut (
    .clk(clk), .rst(rst),
    .scl_pad_i(scl_m), .scl_pad_o(scl_pad_o), .scl_padoen_o(scl_padoen_o),
    .sda_pad_i(sda_line), .sda_pad_o(sda_pad_o), .sda_padoen_o(sda_padoen_o),
    .loc_addr(loc_addr), .loc_data(loc_data),
    .wr_stb(wr_stb), .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy)
  );

  always @(negedge clk) begin
    if (wr_stb) stbq.push_back({wr_addr, wr_data});
    if (!sda_padoen_o) drive_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; tick(Q);
    scl_m = 1'b1; tick(Q);
    sda_m = 1'b0; tick(Q);
    scl_m = 1'b0; tick(Q);
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; tick(Q);
    scl_m = 1'b1; tick(Q);
    sda_m = 1'b1; tick(H);
  endtask

  task automatic put_bit(input logic b, input bit glitch);
    sda_m = b; tick(Q);
    scl_m = 1'b1;
    if (glitch) begin
      tick(4); sda_m = ~b; tick(1); sda_m = b;
      tick(6); scl_m = 1'b0; tick(2); scl_m = 1'b1;
      tick(H - 13);
    end else begin
      tick(H);
    end
    scl_m = 1'b0; tick(Q);
  endtask

  task automatic get_bit(output logic b);
    sda_m = 1'b1; tick(Q);
    scl_m = 1'b1; tick(H / 2);
    b = sda_line; tick(H / 2);
    scl_m = 1'b0; tick(Q);
  endtask

  task automatic write_byte(input logic [7:0] d, input bit glitch, output logic ack);
    for (int i = 7; i >= 0; i--) put_bit(d[i], glitch);
    get_bit(ack);
  endtask

  task automatic read_byte(input logic ack, output logic [7:0] d);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      get_bit(b);
      d[i] = b;
    end
    put_bit(ack, 1'b0);
  endtask

  task automatic check_mem_all();
    for (int a = 0; a < 16; a++) begin
      loc_addr = 4'(a); tick(2);
      chk($sformatf("loc_mem%0d", a), {24'd0, loc_data}, {24'd0, mdl_mem[a]});
    end
  endtask

  // Write transaction of all bytes in wbuf starting at register p
  task automatic xfer_write(input logic [7:0] p, input bit glitch);
    logic        ack;
    logic [11:0] exp_q[$];
    stbq.delete();
    i2c_start();
    write_byte({SA, 1'b0}, 1'b0, ack);
    chk("wr_addr_ack", {31'd0, ack}, 32'd0);
    chk("wr_busy", {31'd0, busy}, 32'd1);
    write_byte(p, 1'b0, ack);
    chk("wr_ptr_ack", {31'd0, ack}, 32'd0);
    mdl_ptr = p % 16;
    for (int i = 0; i < wbuf.size(); i++) begin
      write_byte(wbuf[i], glitch && i == 0, ack);
      chk("wr_data_ack", {31'd0, ack}, 32'd0);
      mdl_mem[mdl_ptr] = wbuf[i];
      exp_q.push_back({4'(mdl_ptr), wbuf[i]});
      mdl_ptr = (mdl_ptr + 1) % 16;
    end
    i2c_stop();
    chk("wr_busy_end", {31'd0, busy}, 32'd0);
    chk("wr_stb_count", stbq.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < stbq.size(); i++)
      chk("wr_stb_entry", {20'd0, stbq[i]}, {20'd0, exp_q[i]});
  endtask

  // Read n bytes, optionally setting the pointer first (write phase + repeated START)
  task automatic xfer_read(input bit use_ptr, input logic [7:0] p, input int n);
    logic       ack;
    logic [7:0] d;
    stbq.delete();
    if (use_ptr) begin
      i2c_start();
      write_byte({SA, 1'b0}, 1'b0, ack);
      chk("rd_waddr_ack", {31'd0, ack}, 32'd0);
      write_byte(p, 1'b0, ack);
      chk("rd_ptr_ack", {31'd0, ack}, 32'd0);
      mdl_ptr = p % 16;
    end
    i2c_start();
    write_byte({SA, 1'b1}, 1'b0, ack);
    chk("rd_addr_ack", {31'd0, ack}, 32'd0);
    for (int i = 0; i < n; i++) begin
      read_byte((i == n - 1), d);
      chk("rd_data", {24'd0, d}, {24'd0, mdl_mem[mdl_ptr]});
      if (i != n - 1) mdl_ptr = (mdl_ptr + 1) % 16;
    end
    i2c_stop();
    chk("rd_busy_end", {31'd0, busy}, 32'd0);
    chk("rd_no_stb", stbq.size(), 32'd0);
  endtask

  initial begin
    logic       ack;
    logic [7:0] p;
    int         n;
    rst = 1'b1; scl_m = 1'b1; sda_m = 1'b1; loc_addr = '0;
    for (int i = 0; i < 16; i++) mdl_mem[i] = 8'h00;
    mdl_ptr = 0;
    tick(4);
    rst = 1'b0;
    tick(3);
    chk("rst_padoen", {31'd0, sda_padoen_o}, 32'd1);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_wr_stb", {31'd0, wr_stb}, 32'd0);
    chk("rst_loc_data", {24'd0, loc_data}, 32'd0);
    chk("const_pads", {29'd0, scl_pad_o, scl_padoen_o, sda_pad_o}, 32'b010);

    // Directed write of two bytes
    wbuf = '{8'hA5, 8'h5A};
    xfer_write(8'h03, 1'b0);
    // Read them back via repeated START
    xfer_read(1'b1, 8'h03, 2);

    // Wrong device address: NACK, nothing driven, nothing written
    drive_cnt = 0; stbq.delete();
    i2c_start();
    write_byte({7'h51, 1'b0}, 1'b0, ack);
    chk("nack_ack", {31'd0, ack}, 32'd1);
    chk("nack_busy", {31'd0, busy}, 32'd0);
    i2c_stop();
    chk("nack_drive", drive_cnt, 32'd0);
    chk("nack_stb", stbq.size(), 32'd0);

    // Pointer wrap
    wbuf = '{8'h11, 8'h22};
    xfer_write(8'h0F, 1'b0);
    loc_addr = 4'h0; tick(2);
    chk("wrap_loc0", {24'd0, loc_data}, 32'h22);
    check_mem_all();

    // Idle glitches, then a transaction with glitches inside every bit of a data byte
    sda_m = 1'b0; tick(1); sda_m = 1'b1; tick(Q);
    scl_m = 1'b0; tick(2); scl_m = 1'b1; tick(Q);
    chk("glitch_idle_busy", {31'd0, busy}, 32'd0);
    wbuf = '{8'h96, 8'h3C};
    xfer_write(8'h07, 1'b1);
    xfer_read(1'b1, 8'h07, 2);

    // Randomized writes and reads against the model
    for (int it = 0; it < 6; it++) begin
      n = int'($urandom_range(1, 3));
      wbuf.delete();
      for (int j = 0; j < n; j++) wbuf.push_back(8'($urandom));
      p = 8'($urandom);
      xfer_write(p, 1'b0);
      p = 8'($urandom);
      xfer_read(($urandom_range(0, 2) != 0), p, int'($urandom_range(1, 3)));
    end
    // Read without pointer phase continues from the last pointer
    xfer_read(1'b0, 8'h00, 2);
    check_mem_all();

    // Reset while the slave is driving a 0 data bit
    wbuf = '{8'h3C};
    xfer_write(8'h05, 1'b0);
    i2c_start();
    write_byte({SA, 1'b0}, 1'b0, ack);
    write_byte(8'h05, 1'b0, ack);
    i2c_start();
    write_byte({SA, 1'b1}, 1'b0, ack);
    chk("rst_mid_ack", {31'd0, ack}, 32'd0);
    chk("rst_mid_driving", {31'd0, sda_padoen_o}, 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rst_mid_release", {31'd0, sda_padoen_o}, 32'd1);
    tick(3);
    rst = 1'b0;
    for (int i = 0; i < 16; i++) mdl_mem[i] = 8'h00;
    mdl_ptr = 0;
    scl_m = 1'b1; tick(Q);
    sda_m = 1'b1; tick(H);
    chk("rst_mid_busy", {31'd0, busy}, 32'd0);
    xfer_read(1'b0, 8'h00, 1);
    check_mem_all();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
